// File: rtl/axi_bw_rr_arbiter.sv
// axi_bw_rr_arbiter
//   Round-robin arbiter for AXI write-response (B) channels. N_INIT_PORT
//   requesters are merged onto one B channel toward the master. A grant is
//   held until the master handshakes, then the round-robin pointer moves past
//   the served port. When no write transaction is outstanding, a DECERR
//   response with a caller-supplied ID/USER can be injected instead.
//   An outstanding counter tracks accepted AWs minus completed B handshakes.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   bid_i/bresp_i/
//   buser_i/bvalid_i    flattened per-requester B channel (port k at slice k)
//   bready_o            per-requester BREADY (only the granted port sees bready_i)
//   bid_o/bresp_o/
//   buser_o/bvalid_o    arbitrated B channel to the master
//   bready_i            master BREADY
//   incr_req_i          one AW accepted, count it as outstanding
//   full_counter_o      outstanding counter is all-ones
//   outstanding_trans_o outstanding counter is non-zero
//   error_req_i/
//   error_id_i/
//   error_user_i        request and payload for an injected DECERR
//   error_gnt_o         injected DECERR accepted by the master this cycle
//   state_o             debug view of the FSM: 0 IDLE, 1 HOLD, 2 ERR
//
// Handshake: a beat transfers on a cycle where valid and ready are both high;
// valid, once presented, and its payload are held stable until that cycle.
module axi_bw_rr_arbiter #(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_ID_OUT  = 19,
  parameter int AXI_USER_W  = 6,
  parameter int CNT_W       = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
  input  logic [N_INIT_PORT*2-1:0]          bresp_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
  input  logic [N_INIT_PORT-1:0]            bvalid_i,
  output logic [N_INIT_PORT-1:0]            bready_o,
  output logic [AXI_ID_IN-1:0]              bid_o,
  output logic [1:0]                        bresp_o,
  output logic [AXI_USER_W-1:0]             buser_o,
  output logic                              bvalid_o,
  input  logic                              bready_i,
  input  logic                              incr_req_i,
  output logic                              full_counter_o,
  output logic                              outstanding_trans_o,
  input  logic                              error_req_i,
  input  logic [AXI_ID_IN-1:0]              error_id_i,
  input  logic [AXI_USER_W-1:0]             error_user_i,
  output logic                              error_gnt_o,
  output logic [1:0]                        state_o
);

  localparam int IDX_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]            state_q;
  logic [IDX_W-1:0]      g_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [AXI_ID_IN-1:0]  err_id_q;
  logic [AXI_USER_W-1:0] err_user_q;

  logic                  found;
  logic [IDX_W-1:0]      sel;
  int                    idx;
  logic                  hs_hold;
  logic [IDX_W-1:0]      ptr_next;

  // Upper BID bits beyond AXI_ID_IN are intentionally dropped on the way out.
  logic unused_bid;
  assign unused_bid = ^bid_i;

  assign full_counter_o      = &cnt_q;
  assign outstanding_trans_o = |cnt_q;
  assign state_o             = state_q;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_INIT_PORT;
      if (!found && bvalid_i[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  assign hs_hold  = (state_q == HOLD) && bvalid_i[g_q] && bready_i;
  assign ptr_next = (g_q == IDX_W'(N_INIT_PORT - 1)) ? '0 : g_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      g_q        <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      err_id_q   <= '0;
      err_user_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Injection only when nothing is outstanding; it beats any bvalid_i.
          if (error_req_i && (cnt_q == '0)) begin
            state_q    <= ERR;
            err_id_q   <= error_id_i;
            err_user_q <= error_user_i;
          end else if (found) begin
            state_q <= HOLD;
            g_q     <= sel;
          end
        end
        HOLD: begin
          if (hs_hold) begin
            state_q  <= IDLE;
            rr_ptr_q <= ptr_next;
          end
        end
        ERR: begin
          if (bready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Saturating up/down counter; simultaneous inc and dec cancel out.
      case ({incr_req_i, hs_hold})
        2'b10:   if (!full_counter_o) cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   if (outstanding_trans_o) cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bvalid_o    = 1'b0;
    bid_o       = '0;
    bresp_o     = 2'b00;
    buser_o     = '0;
    bready_o    = '0;
    error_gnt_o = 1'b0;
    case (state_q)
      HOLD: begin
        bvalid_o      = bvalid_i[g_q];
        bid_o         = bid_i[int'(g_q)*AXI_ID_OUT +: AXI_ID_IN];
        bresp_o       = bresp_i[int'(g_q)*2 +: 2];
        buser_o       = buser_i[int'(g_q)*AXI_USER_W +: AXI_USER_W];
        bready_o[g_q] = bready_i;
      end
      ERR: begin
        bvalid_o    = 1'b1;
        bid_o       = err_id_q;
        bresp_o     = 2'b11;
        buser_o     = err_user_q;
        error_gnt_o = bready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_bw_rr_arbiter.sv
module tb_axi_bw_rr_arbiter;

  localparam int N = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic [N-1:0][18:0] port_id;
  logic [N-1:0][1:0]  port_resp;
  logic [N-1:0][5:0]  port_user;
  logic [N*19-1:0]    bid_i;
  logic [N*2-1:0]     bresp_i;
  logic [N*6-1:0]     buser_i;
  logic [N-1:0]       bvalid_i = '0;
  logic [N-1:0]       bready_o;
  logic [15:0]        bid_o;
  logic [1:0]         bresp_o;
  logic [5:0]         buser_o;
  logic               bvalid_o;
  logic               bready_i = 1'b0;
  logic               incr_req_i = 1'b0;
  logic               full_counter_o;
  logic               outstanding_trans_o;
  logic               error_req_i = 1'b0;
  logic [15:0]        error_id_i = '0;
  logic [5:0]         error_user_i = '0;
  logic               error_gnt_o;
  logic [1:0]         state_o;

  assign bid_i   = port_id;
  assign bresp_i = port_resp;
  assign buser_i = port_user;

  axi_bw_rr_arbiter #(
    .N_INIT_PORT(N), .AXI_ID_IN(16), .AXI_ID_OUT(19), .AXI_USER_W(6), .CNT_W(10)
  ) dut (
    .clk(clk), .rst(rst),
    .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i), .bvalid_i(bvalid_i),
    .bready_o(bready_o), .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .incr_req_i(incr_req_i),
    .full_counter_o(full_counter_o), .outstanding_trans_o(outstanding_trans_o),
    .error_req_i(error_req_i), .error_id_i(error_id_i), .error_user_i(error_user_i),
    .error_gnt_o(error_gnt_o), .state_o(state_o)
  );

  // behavioural model: mode 0 idle, 1 serving port m_g, 2 sending DECERR
  int          m_mode = 0;
  int          m_g = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic [15:0] m_eid = '0;
  logic [5:0]  m_euser = '0;

  always @(posedge clk) begin
    int old_cnt;
    bit hs;
    bit got;
    if (rst) begin
      m_mode = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_eid = '0; m_euser = '0;
    end else begin
      old_cnt = m_cnt;
      hs = (m_mode == 1) && bvalid_i[m_g] && bready_i;
      if (incr_req_i && !hs && m_cnt < 1023) m_cnt = m_cnt + 1;
      else if (hs && !incr_req_i && m_cnt > 0) m_cnt = m_cnt - 1;
      case (m_mode)
        0: begin
          if (error_req_i && old_cnt == 0) begin
            m_mode = 2; m_eid = error_id_i; m_euser = error_user_i;
          end else if (bvalid_i != 0) begin
            got = 0;
            for (int i = 0; i < N; i++) begin
              if (!got && bvalid_i[(m_ptr + i) % N]) begin
                m_g = (m_ptr + i) % N;
                got = 1;
              end
            end
            m_mode = 1;
          end
        end
        1: if (hs) begin m_mode = 0; m_ptr = (m_g + 1) % N; end
        2: if (bready_i) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  // scoreboard
  int          tests_run = 0;
  int          fail_cnt = 0;
  bit          chk_en = 0;
  bit          auto_drop = 1;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [15:0] e_bid;
    logic [1:0]  e_resp;
    logic [5:0]  e_user;
    logic [N-1:0] e_rdy;
    logic        e_vld;
    logic [18:0] pid;
    e_bid = '0; e_resp = '0; e_user = '0; e_rdy = '0; e_vld = 1'b0;
    if (m_mode == 1) begin
      pid    = port_id[m_g];
      e_vld  = bvalid_i[m_g];
      e_bid  = pid[15:0];
      e_resp = port_resp[m_g];
      e_user = port_user[m_g];
      e_rdy[m_g] = bready_i;
    end else if (m_mode == 2) begin
      e_vld = 1'b1; e_bid = m_eid; e_resp = 2'b11; e_user = m_euser;
    end
    check("bvalid_o", 32'(bvalid_o), 32'(e_vld));
    check("bid_o", 32'(bid_o), 32'(e_bid));
    check("bresp_o", 32'(bresp_o), 32'(e_resp));
    check("buser_o", 32'(buser_o), 32'(e_user));
    check("bready_o", 32'(bready_o), 32'(e_rdy));
    check("full_counter_o", 32'(full_counter_o), 32'(m_cnt == 1023));
    check("outstanding_trans_o", 32'(outstanding_trans_o), 32'(m_cnt != 0));
    check("error_gnt_o", 32'(error_gnt_o), 32'((m_mode == 2) && bready_i));
    check("state_o", 32'(state_o), 32'(m_mode));
  endtask

  // driver: one clock per call; compares at negedge, drives at posedge+1.
  // A requester drops its valid after its handshake, like a real slave.
  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    if (chk_en) compare_all();
    if (bvalid_o && bready_i) got_q.push_back(bid_o);
    hs = bvalid_i & bready_o;
    @(posedge clk);
    #1;
    if (auto_drop) bvalid_i = bvalid_i & ~hs;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      port_id[k]   = 19'h70000 | 19'(16'hA000 + k);
      port_resp[k] = 2'(k);
      port_user[k] = 6'(k + 8);
    end

    // reset
    tick(); tick();
    chk_en = 1;
    settle();
    check("reset bvalid_o", 32'(bvalid_o), 32'd0);
    check("reset bready_o", 32'(bready_o), 32'd0);
    check("reset state_o", 32'(state_o), 32'd0);
    check("reset outstanding", 32'(outstanding_trans_o), 32'd0);
    check("reset error_gnt_o", 32'(error_gnt_o), 32'd0);
    rst = 1'b0;

    // S1: 4'b1010 from ptr 0 -> port 1 then port 3, then ptr back at 0
    bready_i = 1'b1;
    bvalid_i = 4'b1010;
    tick(); settle();
    check("s1 latency bvalid_o", 32'(bvalid_o), 32'd1);
    check("s1 first bid_o", 32'(bid_o), 32'hA001);
    tick(); settle();
    check("s1 idle gap bvalid_o", 32'(bvalid_o), 32'd0);
    tick(); settle();
    check("s1 second bid_o", 32'(bid_o), 32'hA003);
    tick();
    exp_q.push_back(16'hA001); exp_q.push_back(16'hA003);
    bvalid_i = 4'b1001;
    tick(); settle();
    check("s1 ptr wrapped to 0", 32'(bid_o), 32'hA000);
    tick(); tick(); tick();
    exp_q.push_back(16'hA000); exp_q.push_back(16'hA003);

    // S2: port 2 held with bready low; port 0 arriving does not preempt
    bready_i = 1'b0;
    bvalid_i = 4'b0100;
    tick();
    tick(); tick();
    bvalid_i[0] = 1'b1;
    tick(); tick(); tick(); settle();
    check("s2 no preempt bid_o", 32'(bid_o), 32'hA002);
    check("s2 held bvalid_o", 32'(bvalid_o), 32'd1);
    bready_i = 1'b1; settle();
    check("s2 bready_o on handshake", 32'(bready_o), 32'b0100);
    tick();
    tick(); tick();
    exp_q.push_back(16'hA002); exp_q.push_back(16'hA000);

    // S3: DECERR injection with counter 0, wins over a pending bvalid_i
    bready_i = 1'b0;
    error_req_i = 1'b1; error_id_i = 16'h001A; error_user_i = 6'h15;
    bvalid_i = 4'b0010;
    tick();
    error_req_i = 1'b0; settle();
    check("s3 err bvalid_o", 32'(bvalid_o), 32'd1);
    check("s3 err bresp_o", 32'(bresp_o), 32'h3);
    check("s3 err bid_o", 32'(bid_o), 32'h1A);
    check("s3 err buser_o", 32'(buser_o), 32'h15);
    check("s3 err bready_o", 32'(bready_o), 32'd0);
    check("s3 gnt before ready", 32'(error_gnt_o), 32'd0);
    tick(); tick();
    bready_i = 1'b1; settle();
    check("s3 gnt on ready", 32'(error_gnt_o), 32'd1);
    tick(); settle();
    check("s3 gnt one cycle", 32'(error_gnt_o), 32'd0);
    check("s3 counter stays 0", 32'(outstanding_trans_o), 32'd0);
    tick(); tick();
    exp_q.push_back(16'h001A); exp_q.push_back(16'hA001);

    // S4: error request ignored while transactions are outstanding
    incr_req_i = 1'b1;
    tick(); tick(); tick();
    incr_req_i = 1'b0; settle();
    check("s4 outstanding", 32'(outstanding_trans_o), 32'd1);
    error_req_i = 1'b1;
    bvalid_i = 4'b0100;
    tick(); settle();
    check("s4 no err state", 32'(state_o), 32'd1);
    check("s4 normal bid_o", 32'(bid_o), 32'hA002);
    error_req_i = 1'b0;
    tick();
    exp_q.push_back(16'hA002);

    // S5: saturation at 1023 and inc+dec cancelling
    incr_req_i = 1'b1;
    for (int i = 0; i < 1021; i++) tick();
    settle();
    check("s5 full at 1023", 32'(full_counter_o), 32'd1);
    tick(); settle();
    check("s5 saturated full", 32'(full_counter_o), 32'd1);
    bvalid_i = 4'b0001;
    tick(); tick(); settle();
    check("s5 inc+dec unchanged", 32'(full_counter_o), 32'd1);
    incr_req_i = 1'b0;
    bvalid_i = 4'b0010;
    tick(); tick(); settle();
    check("s5 dec from full", 32'(full_counter_o), 32'd0);
    check("s5 still outstanding", 32'(outstanding_trans_o), 32'd1);
    exp_q.push_back(16'hA000); exp_q.push_back(16'hA001);

    // S6: reset during HOLD aborts the transfer
    bready_i = 1'b0;
    bvalid_i = 4'b1000;
    tick(); settle();
    check("s6 in hold", 32'(state_o), 32'd1);
    rst = 1'b1;
    tick(); settle();
    check("s6 rst bvalid_o", 32'(bvalid_o), 32'd0);
    check("s6 rst bready_o", 32'(bready_o), 32'd0);
    check("s6 rst state_o", 32'(state_o), 32'd0);
    check("s6 rst counter", 32'(outstanding_trans_o), 32'd0);
    rst = 1'b0;
    bready_i = 1'b1;
    tick(); tick(); tick(); tick();
    exp_q.push_back(16'hA003);

    // handshake order scoreboard
    check("handshake count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check("handshake bid", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
